clk_period_meter: RTL and testbench

Measures the period of an externally divided clock `clk_meas` in `clk_in` cycles and recovers the divider's `scale` setting. It is the receive-side counterpart of the team's clock divider: a divider programmed with `scale = S` toggles every S cycles, so its period is 2·S, and this block reports `scale_out = period/2`. It sits on the bring-up and self-test path, with the result delivered to a consumer over a valid/ready handshake.

---
 rtl/clk_period_meter.sv | 144 ++++++++++++++
 tb/tb_clk_period_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Purpose: measures the period of clk_meas in clk_in cycles and recovers the divider scale (period/2, saturated).
// Latency: result valid the cycle after the terminating synchronized rising edge; timeout after 2^CNT_WIDTH-1 cycles.
// Backpressure: result held stable in DONE until valid&ready; start is ignored while busy.
// Option: define CLK_PERIOD_METER_CONTINUOUS_EN to re-arm automatically after each accepted result.
module clk_period_meter #(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 nrst,
    input  logic                 clk_meas,
    input  logic                 start,
    input  logic                 ready,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [WIDTH-1:0]     scale_out,
    output logic                 timeout,
    output logic                 busy
);
    // Common width for comparing the halved count against the scale ceiling.
    localparam int XW = (WIDTH > CNT_WIDTH) ? WIDTH : CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [CNT_WIDTH-1:0]   period_nxt;
    logic [WIDTH-1:0]       scale_nxt;
    logic [WIDTH-1:0]       scale_clamp;
    logic                   timeout_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meas_d;
    logic                   rise;
    logic [XW-1:0]          half_x;

    // Synchronizer chain for clk_meas plus one delay flop for edge detection.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            meas_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_meas};
            meas_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise  = sync_q[SYNC_STAGES-1] & ~meas_d;
    assign valid = (state == ST_DONE);
    assign busy  = (state != ST_IDLE);

    // Recovered scale: half the period, saturated to the scale width.
    always_comb begin
        half_x = XW'(cnt >> 1);
        if (half_x > XW'({WIDTH{1'b1}})) begin
            scale_clamp = '1;
        end else begin
            scale_clamp = half_x[WIDTH-1:0];
        end
    end

    // Next-state and next-result logic; a rise beats counter saturation.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period_out;
        scale_nxt   = scale_out;
        timeout_nxt = timeout;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    cnt_nxt   = CNT_WIDTH'(1);
                    state_nxt = ST_COUNT;
                end else if (cnt == CNT_MAX) begin
                    period_nxt  = '1;
                    scale_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            ST_COUNT: begin
                if (rise) begin
                    period_nxt  = cnt;
                    scale_nxt   = scale_clamp;
                    timeout_nxt = 1'b0;
                    state_nxt   = ST_DONE;
                end else if (cnt == CNT_MAX) begin
                    period_nxt  = '1;
                    scale_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (ready) begin
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
                    cnt_nxt   = '0;
                    state_nxt = ST_ARM;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and held result registers.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            period_out <= '0;
            scale_out  <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_out <= period_nxt;
            scale_out  <= scale_nxt;
            timeout    <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// Purpose: self-checking bench for clk_period_meter against a period/scale model.
// Latency: results checked every cycle valid is high; all waits bounded.
// Backpressure: ready driven by directed tasks; held low to exercise result stability.
`timescale 1ns/1ps
module tb_clk_period_meter;
    localparam int WIDTH       = 8;
    localparam int CNT_WIDTH   = 16;
    localparam int SYNC_STAGES = 2;
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic                 clk_in   = 1'b0;
    logic                 nrst     = 1'b0;
    logic                 clk_meas = 1'b0;
    logic                 start    = 1'b0;
    logic                 ready    = 1'b0;
    logic                 valid;
    logic [CNT_WIDTH-1:0] period_out;
    logic [WIDTH-1:0]     scale_out;
    logic                 timeout;
    logic                 busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int meas_hi   = 0;
    int meas_lo   = 0;
    int ph_cnt    = 0;
    bit meas_en   = 1'b0;
    bit cmp_en    = 1'b0;
    int exp_period  = 0;
    int exp_scale   = 0;
    bit exp_timeout = 1'b0;
    int n_results   = 0;
    int lat         = 0;

    clk_period_meter #(
        .WIDTH      (WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in    (clk_in),
        .nrst      (nrst),
        .clk_meas  (clk_meas),
        .start     (start),
        .ready     (ready),
        .valid     (valid),
        .period_out(period_out),
        .scale_out (scale_out),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    // Model: a divider with scale S yields period 2S; scale is period/2 saturated.
    function automatic int model_scale(input int period);
        int half;
        half = period / 2;
        if (half > (1 << WIDTH) - 1) return (1 << WIDTH) - 1;
        return half;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Divided-clock source: low for meas_lo cycles, high for meas_hi, toggled on falling clk_in.
    always @(negedge clk_in) begin
        if (!meas_en) begin
            clk_meas = 1'b0;
            ph_cnt   = 0;
        end else begin
            ph_cnt = ph_cnt + 1;
            if (clk_meas && ph_cnt >= meas_hi) begin
                clk_meas = 1'b0;
                ph_cnt   = 0;
            end else if (!clk_meas && ph_cnt >= meas_lo) begin
                clk_meas = 1'b1;
                ph_cnt   = 0;
            end
        end
    end

    // Compare every cycle a result is presented against the model expectation.
    always @(negedge clk_in) begin
        if (nrst && cmp_en && valid) begin
            check("cmp_period", 32'(period_out), 32'(exp_period));
            check("cmp_scale", 32'(scale_out), 32'(exp_scale));
            check("cmp_timeout", 32'(timeout), 32'(exp_timeout));
            if (ready) n_results++;
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        nrst = 1'b0;
        repeat (2) @(negedge clk_in);
        nrst = 1'b1;
    endtask

    task automatic set_meas(input int hi, input int lo);
        meas_en = 1'b0;
        repeat (3) @(negedge clk_in);
        meas_hi     = hi;
        meas_lo     = lo;
        exp_period  = hi + lo;
        exp_scale   = model_scale(hi + lo);
        exp_timeout = 1'b0;
        meas_en     = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name, output int cycles);
        cycles = 0;
        while (!valid && cycles < bound) begin
            @(negedge clk_in);
            cycles++;
        end
        check({name, "_valid_seen"}, 32'(valid), 1);
    endtask

    task automatic handshake(input string name);
        ready = 1'b1;
        @(negedge clk_in);
        ready = 1'b0;
        check({name, "_valid_fall"}, 32'(valid), 0);
        check({name, "_busy_after"}, 32'(busy), 32'(CONT));
    endtask

    task automatic measure(input int hi, input int lo, input string name);
        int c;
        if (CONT) do_reset();
        set_meas(hi, lo);
        pulse_start();
        check({name, "_busy_rise"}, 32'(busy), 1);
        wait_valid(3000, name, c);
    endtask

    initial begin
        // Reset values
        nrst = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_valid", 32'(valid), 0);
        check("rst_period", 32'(period_out), 0);
        check("rst_scale", 32'(scale_out), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        nrst   = 1'b1;
        cmp_en = 1'b1;

        // Divider scale 5: period 10
        measure(5, 5, "p10");
        check("p10_period_lit", 32'(period_out), 10);
        check("p10_scale_lit", 32'(scale_out), 5);
        check("p10_timeout_lit", 32'(timeout), 0);
        handshake("p10");

        // Odd period truncates
        measure(3, 4, "p7");
        check("p7_period_lit", 32'(period_out), 7);
        check("p7_scale_lit", 32'(scale_out), 3);
        handshake("p7");

        // Scale saturation, then back-pressure with a stray start
        measure(300, 300, "p600");
        check("p600_period_lit", 32'(period_out), 600);
        check("p600_scale_lit", 32'(scale_out), 255);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            @(negedge clk_in);
            check("bp_valid_hold", 32'(valid), 1);
            check("bp_period_hold", 32'(period_out), 600);
        end
        handshake("p600");
        @(negedge clk_in);
        check("bp_start_ignored", 32'(busy), 32'(CONT));

        // Reset in the middle of a period-40 count
        if (CONT) do_reset();
        set_meas(20, 20);
        pulse_start();
        repeat (40) @(negedge clk_in);
        check("mid_busy", 32'(busy), 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_period", 32'(period_out), 0);
        check("mid_rst_scale", 32'(scale_out), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk_in);
        nrst = 1'b1;
        pulse_start();
        wait_valid(3000, "p40", lat);
        check("p40_period_lit", 32'(period_out), 40);
        check("p40_scale_lit", 32'(scale_out), 20);
        handshake("p40");

        // Stuck clk_meas: timeout
        if (CONT) do_reset();
        meas_en     = 1'b0;
        exp_period  = (1 << CNT_WIDTH) - 1;
        exp_scale   = 0;
        exp_timeout = 1'b1;
        repeat (2) @(negedge clk_in);
        pulse_start();
        wait_valid(70000, "tmo", lat);
        check("tmo_latency_in_range", 32'(lat >= 65535 && lat <= 65537), 1);
        check("tmo_flag_lit", 32'(timeout), 1);
        check("tmo_period_lit", 32'(period_out), 32'h0000FFFF);
        check("tmo_scale_lit", 32'(scale_out), 0);
        handshake("tmo");

`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
        // Continuous re-arm: one start, ready held high
        do_reset();
        set_meas(5, 5);
        n_results = 0;
        ready     = 1'b1;
        pulse_start();
        repeat (300) @(negedge clk_in);
        check("cont_results", 32'(n_results >= 3), 1);
        check("cont_busy", 32'(busy), 1);
        ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
